// File: rtl/mario_motion_ctrl.sv
// Per-frame position sequencer for Mario's sprite: erase at the old X/Y, step the
// position from the buttons and the jump arc, then draw at the new X/Y via req/done.
module mario_motion_ctrl #(
  parameter int X_INIT      = 4,
  parameter int Y_INIT      = 89,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 152,
  parameter int JUMP_HEIGHT = 24
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  input  logic       draw_done,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic       erase_req,
  output logic       draw_req,
  output logic       busy,
  output logic       on_ground
);

  localparam logic [7:0] LP_X_INIT = 8'(X_INIT);
  localparam logic [7:0] LP_Y_INIT = 8'(Y_INIT);
  localparam logic [7:0] LP_X_MIN  = 8'(X_MIN);
  localparam logic [7:0] LP_X_MAX  = 8'(X_MAX);
  localparam logic [7:0] LP_JH     = 8'(JUMP_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_WAIT, S_ERASE, S_UPDATE, S_DRAW
  } state_t;

  typedef enum logic [1:0] {PH_NONE, PH_RISE, PH_FALL} phase_t;

  state_t     r_state;
  phase_t     r_phase;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic [7:0] r_rise_cnt;
  logic       r_tick_pend;
  logic       r_erase_req;
  logic       r_draw_req;
  logic       r_busy;
  logic       r_on_ground;

  logic [7:0] w_x_nxt;
  logic [7:0] w_y_nxt;
  logic [7:0] w_rise_nxt;
  phase_t     w_phase_nxt;
  logic       w_gnd_nxt;

  // Bounds are checked before stepping so x never wraps through 0 or 255.
  always_comb begin
    w_x_nxt = r_x;
    if (right && !left && (r_x < LP_X_MAX))
      w_x_nxt = r_x + 8'd1;
    else if (left && !right && (r_x > LP_X_MIN))
      w_x_nxt = r_x - 8'd1;

    w_y_nxt     = r_y;
    w_rise_nxt  = r_rise_cnt;
    w_phase_nxt = r_phase;
    // r_rise_cnt holds rows climbed so far, including the launch row.
    case (r_phase)
      PH_NONE: begin
        if (jump) begin
          w_y_nxt     = r_y - 8'd1;
          w_rise_nxt  = 8'd1;
          w_phase_nxt = (LP_JH == 8'd1) ? PH_FALL : PH_RISE;
        end
      end
      PH_RISE: begin
        w_y_nxt    = r_y - 8'd1;
        w_rise_nxt = r_rise_cnt + 8'd1;
        if (w_rise_nxt == LP_JH)
          w_phase_nxt = PH_FALL;
      end
      PH_FALL: begin
        if (r_y < LP_Y_INIT)
          w_y_nxt = r_y + 8'd1;
        if (w_y_nxt == LP_Y_INIT)
          w_phase_nxt = PH_NONE;
      end
      default: w_phase_nxt = PH_NONE;
    endcase
    w_gnd_nxt = (w_y_nxt == LP_Y_INIT) && (w_phase_nxt == PH_NONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_NONE;
      r_x         <= LP_X_INIT;
      r_y         <= LP_Y_INIT;
      r_rise_cnt  <= 8'd0;
      r_tick_pend <= 1'b0;
      r_erase_req <= 1'b0;
      r_draw_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_on_ground <= 1'b1;
    end else begin
      // One-deep tick buffer; leaving WAIT always consumes whatever tick is there.
      if (r_state == S_WAIT)
        r_tick_pend <= 1'b0;
      else if (r_busy && frame_tick)
        r_tick_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FIRST;
            r_x         <= LP_X_INIT;
            r_y         <= LP_Y_INIT;
            r_phase     <= PH_NONE;
            r_rise_cnt  <= 8'd0;
            r_on_ground <= 1'b1;
            r_draw_req  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_FIRST: begin
          if (draw_done) begin
            r_draw_req <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_tick || r_tick_pend) begin
            r_erase_req <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ERASE;
          end
        end
        S_ERASE: begin
          if (draw_done) begin
            r_erase_req <= 1'b0;
            r_state     <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_x         <= w_x_nxt;
          r_y         <= w_y_nxt;
          r_phase     <= w_phase_nxt;
          r_rise_cnt  <= w_rise_nxt;
          r_on_ground <= w_gnd_nxt;
          r_draw_req  <= 1'b1;
          r_state     <= S_DRAW;
        end
        S_DRAW: begin
          if (draw_done) begin
            r_draw_req <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign erase_req = r_erase_req;
  assign draw_req  = r_draw_req;
  assign busy      = r_busy;
  assign on_ground = r_on_ground;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Scoreboard bench for mario_motion_ctrl: directed frames push expected erase/draw
// requests, a monitor pops and compares them as the DUT raises each request.
module tb_mario_motion_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       jump = 1'b0;
  logic       draw_done = 1'b0;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic       erase_req;
  logic       draw_req;
  logic       busy;
  logic       on_ground;

  mario_motion_ctrl dut (
    .clock(clock), .resetn(resetn), .start(start), .frame_tick(frame_tick),
    .left(left), .right(right), .jump(jump), .draw_done(draw_done),
    .x_out(x_out), .y_out(y_out), .erase_req(erase_req), .draw_req(draw_req),
    .busy(busy), .on_ground(on_ground)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       kind;   // 0 = erase, 1 = draw
    logic [7:0] x;
    logic [7:0] y;
    logic       g;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  n_events = 0;
  int  done_dly = 2;

  logic [7:0] e_x = 8'd4;
  logic [7:0] e_y = 8'd89;
  logic       e_g = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input logic k, input logic [7:0] x, input logic [7:0] y, input logic g);
    ev_t e;
    e.kind = k; e.x = x; e.y = y; e.g = g;
    q.push_back(e);
  endtask

  // One frame: erase at the current model position, draw at the given one.
  task automatic exp_frame(input logic [7:0] nx, input logic [7:0] ny, input logic ng);
    push_ev(1'b0, e_x, e_y, e_g);
    push_ev(1'b1, nx, ny, ng);
    e_x = nx; e_y = ny; e_g = ng;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic frame();
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
    wait_idle();
  endtask

  // Drawer model: acknowledges each request so that it stays high done_dly cycles.
  always begin
    @(posedge clock); #1;
    if ((erase_req || draw_req) && !draw_done) begin
      int n = 1;
      while (n < done_dly && (erase_req || draw_req)) begin
        @(posedge clock); #1;
        n++;
      end
      if (erase_req || draw_req) begin
        draw_done = 1'b1;
        @(posedge clock); #1;
        draw_done = 1'b0;
      end
    end
  end

  logic       prev_e = 1'b0;
  logic       prev_d = 1'b0;
  logic [7:0] held_x = 8'd0;
  logic [7:0] held_y = 8'd0;

  always @(negedge clock) begin
    if (!resetn) begin
      prev_e = 1'b0;
      prev_d = 1'b0;
    end else begin
      if ((erase_req && !prev_e) || (draw_req && !prev_d)) begin
        ev_t e;
        n_events++;
        held_x = x_out;
        held_y = y_out;
        chk("req_overlap", int'(erase_req && draw_req), 0);
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req: got kind=%0d x=%0d y=%0d expected none", draw_req, x_out, y_out);
        end else begin
          e = q.pop_front();
          if (e.kind != draw_req || e.x != x_out || e.y != y_out || e.g != on_ground) begin
            failures++;
            $display("FAIL req_event: got kind=%0d x=%0d y=%0d g=%0d expected kind=%0d x=%0d y=%0d g=%0d",
                     draw_req, x_out, y_out, on_ground, e.kind, e.x, e.y, e.g);
          end
        end
      end else if (erase_req || draw_req) begin
        chk("x_stable", int'(x_out), int'(held_x));
        chk("y_stable", int'(y_out), int'(held_y));
      end
      prev_e = erase_req;
      prev_d = draw_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    int ev0;

    // Test 1: reset state, then first draw at (4,89) held 3 cycles.
    repeat (3) @(negedge clock);
    chk("rst_x", int'(x_out), 4);
    chk("rst_y", int'(y_out), 89);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ground", int'(on_ground), 1);
    chk("rst_reqs", int'({erase_req, draw_req}), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_no_req", int'({erase_req, draw_req}), 0);
    done_dly = 3;
    push_ev(1'b1, 8'd4, 8'd89, 1'b1);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cnt = 0; n = 0;
    while (busy && n < 50) begin
      if (draw_req) cnt++;
      @(negedge clock);
      n++;
    end
    chk("first_draw_cycles", cnt, 3);
    chk("first_wait_busy", int'(busy), 0);
    chk("first_wait_reqs", int'({erase_req, draw_req}), 0);

    // Test 2: right held for 5 frames.
    done_dly = 2;
    right = 1'b1;
    for (int i = 5; i <= 9; i++) begin
      exp_frame(8'(i), 8'd89, 1'b1);
      frame();
    end
    chk("walk_x", int'(x_out), 9);

    // Test 3: saturate at 152 and 0; both buttons hold x.
    done_dly = 1;
    while (e_x < 8'd152) begin
      exp_frame(e_x + 8'd1, 8'd89, 1'b1);
      frame();
    end
    for (int i = 0; i < 2; i++) begin
      exp_frame(8'd152, 8'd89, 1'b1);
      frame();
    end
    chk("sat_max", int'(x_out), 152);
    right = 1'b0; left = 1'b1;
    while (e_x > 8'd0) begin
      exp_frame(e_x - 8'd1, 8'd89, 1'b1);
      frame();
    end
    for (int i = 0; i < 2; i++) begin
      exp_frame(8'd0, 8'd89, 1'b1);
      frame();
    end
    chk("sat_min", int'(x_out), 0);
    left = 1'b0; right = 1'b1;
    exp_frame(8'd1, 8'd89, 1'b1);
    frame();
    left = 1'b1;
    exp_frame(8'd1, 8'd89, 1'b1);
    frame();
    chk("both_hold", int'(x_out), 1);
    left = 1'b0; right = 1'b0;

    // Test 4: one jump: 88 down to 65, then back to 89.
    jump = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i < 24) exp_frame(8'd1, 8'(88 - i), 1'b0);
      else        exp_frame(8'd1, 8'(66 + (i - 24)), (i == 47) ? 1'b1 : 1'b0);
      frame();
      jump = 1'b0;
      if (i == 23) chk("peak_y", int'(y_out), 65);
    end
    chk("land_y", int'(y_out), 89);
    chk("land_ground", int'(on_ground), 1);

    // Test 5: three ticks during one slow frame give exactly one extra frame.
    done_dly = 10;
    ev0 = n_events;
    exp_frame(8'd1, 8'd89, 1'b1);
    exp_frame(8'd1, 8'd89, 1'b1);
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock) frame_tick = 1'b1;
      @(negedge clock) frame_tick = 1'b0;
    end
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (40) @(negedge clock);
    chk("pend_events", n_events - ev0, 4);
    chk("pend_idle", int'(busy), 0);
    // start outside IDLE must do nothing.
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (20) @(negedge clock);
    chk("start_ignored", n_events - ev0, 4);

    // Test 6: reset in the middle of a draw.
    done_dly = 30;
    right = 1'b1;
    exp_frame(8'd2, 8'd89, 1'b1);
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
    n = 0;
    while (!draw_req && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("draw_seen", int'(draw_req), 1);
    repeat (3) @(negedge clock);
    @(posedge clock); #3;
    resetn = 1'b0;
    #1;
    chk("abort_draw_req", int'(draw_req), 0);
    chk("abort_x", int'(x_out), 4);
    chk("abort_y", int'(y_out), 89);
    chk("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    right = 1'b0;
    done_dly = 2;
    e_x = 8'd4; e_y = 8'd89; e_g = 1'b1;
    push_ev(1'b1, 8'd4, 8'd89, 1'b1);
    repeat (2) @(negedge clock);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_idle();
    chk("restart_x", int'(x_out), 4);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
